dct_framer: RTL and testbench
=============================

Name: dct_framer

Overview:
- Upstream feeder for the DCT pipeline. Takes an unframed complex sample stream and emits Avalon-ST frames of exactly N samples, with sop/eop, for the DCT sink port.
- N is sampled from fftpts_in at each frame start and held for the whole frame.
- An internal FIFO absorbs backpressure from the DCT ping-pong input, so that input can deassert ready between frames.

Parameters:
- wData, 16, bit width of real and imag samples.
- FIFO_AW, 4, FIFO address width; depth is 2^FIFO_AW entries.
- DEF_PTS, 64, frame length used after reset until a valid fftpts_in is captured.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample this cycle.
- in_real  in  wData  input real part.
- in_imag  in  wData  input imag part.
- fftpts_in  in  12  requested frame length.
- source_valid  out  1  output beat valid.
- source_ready  in  1  downstream accepts beat.
- source_error  out  2  2'b01 = frame built with a substituted length; 2'b00 otherwise.
- source_sop  out  1  first beat of frame.
- source_eop  out  1  last beat of frame.
- source_real  out  wData  output real part.
- source_imag  out  wData  output imag part.
- fftpts_out  out  12  length of the frame currently at the output.
- frame_cnt  out  16  count of completed output frames; wraps at 65535 -> 0.

Behaviour:
- Reset (async, rst=1): all state clears immediately.
  - FIFO empty, so in_ready=0 during reset and 1 on the first clk after release.
  - source_valid/sop/eop=0, source_error=0, source_real/imag=0, frame_cnt=0.
  - Current length cur_n=DEF_PTS, fftpts_out=DEF_PTS.
  - A partial frame in flight is discarded; no eop is emitted for it.
- Write side:
  - Accept when in_valid && in_ready, with in_ready = !full (full is registered).
  - Write index idx counts 0..cur_n-1 and wraps to 0 after cur_n-1.
- Frame start (idx==0 on an accepted write):
  - fftpts_in is valid if it is a power of 2 in [8, 2048].
  - Valid: cur_n <= fftpts_in, err <= 0.
  - Invalid: cur_n is kept (last valid length, or DEF_PTS after reset) and err <= 1.
  - The length decision uses fftpts_in in that same cycle, so the first sample's own sop/eop/len tags already reflect it.
- FIFO entry contents: {sop=(idx==0), eop=(idx==cur_n-1), err, len(12), real, imag}.
  - fftpts_in changes mid-frame are ignored.
- Read side: first-word-fall-through.
  - source_* are driven directly from the FIFO head; source_valid = !empty.
  - Pop on source_valid && source_ready.
  - Outputs hold stable while valid && !ready.
  - Minimum latency: in_valid accepted at cycle t -> source_valid at t+1 when the FIFO was empty.
- Counters:
  - FIFO occupancy updates +1 on write only, -1 on read only, unchanged on simultaneous read and write.
  - full = (count==2^FIFO_AW); empty = (count==0).
  - Full with simultaneous pop: in_ready is still 0 that cycle and rises the next cycle. No same-cycle pass-through.
- frame_cnt increments on every popped beat with eop=1.
- fftpts_out follows the len field of the FIFO head. It holds its last value when the FIFO is empty.
- Throughput: 1 sample/cycle sustained when source_ready=1.
- Frame composition: sop and eop occur exactly once per N popped beats. Frames are never merged or truncated, except by reset.

Test Plan:
- Reset release, fftpts_in=8, continuous in_valid, source_ready=1, samples 0..15 -> two frames of 8 beats; sop on values 0 and 8, eop on 7 and 15; first source_valid 1 cycle after the first accept; frame_cnt=2; error=0.
- fftpts_in switches 8->16 at sample 3 -> first frame still 8 beats with fftpts_out=8; next frame is 16 beats with fftpts_out=16.
- fftpts_in=12 at frame start (previous valid length 32) -> 32-beat frame with source_error=2'b01 on every beat and fftpts_out=32. A following frame with fftpts_in=32 has error=0.
- source_ready=0 for 40 cycles, FIFO_AW=4, continuous input -> exactly 16 accepts, then in_ready=0. After ready=1, data comes out in order with no loss; in_ready rises the cycle after the first pop.
- Random source_ready toggling (50%) over 10 frames of 64 -> every beat matches a reference queue, sop/eop positions are correct, and outputs stay stable while stalled.
- rst asserted mid-frame (sample 5 of 16) -> outputs clear immediately. After release, the next accepted sample carries sop, cur_n restarts from a fresh fftpts_in capture, and frame_cnt=0.

Source files
------------

// File: rtl/dct_framer.sv
// Frames an unframed complex sample stream into Avalon-ST frames of N samples
// for the DCT sink, with a first-word-fall-through FIFO absorbing backpressure.
module dct_framer #(
    parameter int wData   = 16,
    parameter int FIFO_AW = 4,
    parameter int DEF_PTS = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [wData-1:0] in_real,
    input  logic [wData-1:0] in_imag,
    input  logic [11:0]      fftpts_in,
    output logic             source_valid,
    input  logic             source_ready,
    output logic [1:0]       source_error,
    output logic             source_sop,
    output logic             source_eop,
    output logic [wData-1:0] source_real,
    output logic [wData-1:0] source_imag,
    output logic [11:0]      fftpts_out,
    output logic [15:0]      frame_cnt
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int EW    = 2 * wData + 15;
    localparam int LEN_LO = 2 * wData;
    localparam int ERR_B  = 2 * wData + 12;
    localparam int EOP_B  = 2 * wData + 13;
    localparam int SOP_B  = 2 * wData + 14;

    logic [EW-1:0]      mem_r [DEPTH];
    logic [FIFO_AW-1:0] wptr_r;
    logic [FIFO_AW-1:0] rptr_r;
    logic [FIFO_AW:0]   count_r;
    logic [FIFO_AW:0]   count_s;
    logic               rdy_r;
    logic [11:0]        idx_r;
    logic [11:0]        cur_n_r;
    logic               err_r;
    logic [11:0]        last_len_r;
    logic [15:0]        frame_cnt_r;

    logic               wr_s;
    logic               rd_s;
    logic               empty_s;
    logic [11:0]        n_s;
    logic               err_s;
    logic               sop_s;
    logic               eop_s;
    logic [EW-1:0]      entry_s;
    logic [EW-1:0]      head_s;

    // Frame lengths must be a power of two between 8 and 2048.
    function automatic logic len_valid(input logic [11:0] x);
        return (x >= 12'd8) && (x <= 12'd2048) && ((x & (x - 12'd1)) == 12'd0);
    endfunction

    assign wr_s    = in_valid & rdy_r;
    assign empty_s = (count_r == '0);
    assign rd_s    = ~empty_s & source_ready;
    assign head_s  = mem_r[rptr_r];

    // Length/error decision and entry tagging; the first sample sees its own frame length.
    always_comb begin
        n_s   = cur_n_r;
        err_s = err_r;
        if (idx_r == 12'd0) begin
            if (len_valid(fftpts_in)) begin
                n_s   = fftpts_in;
                err_s = 1'b0;
            end else begin
                n_s   = cur_n_r;
                err_s = 1'b1;
            end
        end else begin
            n_s   = cur_n_r;
            err_s = err_r;
        end
        sop_s   = (idx_r == 12'd0);
        eop_s   = (idx_r == n_s - 12'd1);
        entry_s = {sop_s, eop_s, err_s, n_s, in_real, in_imag};
    end

    // Occupancy next-state.
    always_comb begin
        count_s = count_r;
        case ({wr_s, rd_s})
            2'b10:   count_s = count_r + {{FIFO_AW{1'b0}}, 1'b1};
            2'b01:   count_s = count_r - {{FIFO_AW{1'b0}}, 1'b1};
            default: count_s = count_r;
        endcase
    end

    // FIFO storage; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_r[wptr_r] <= entry_s;
        end
    end

    // Pointers, occupancy, registered ready, framing state and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_r      <= '0;
            rptr_r      <= '0;
            count_r     <= '0;
            rdy_r       <= 1'b0;
            idx_r       <= 12'd0;
            cur_n_r     <= 12'(DEF_PTS);
            err_r       <= 1'b0;
            last_len_r  <= 12'(DEF_PTS);
            frame_cnt_r <= 16'd0;
        end else begin
            count_r <= count_s;
            rdy_r   <= (count_s != (FIFO_AW + 1)'(DEPTH));
            if (wr_s) begin
                wptr_r  <= wptr_r + {{(FIFO_AW-1){1'b0}}, 1'b1};
                idx_r   <= eop_s ? 12'd0 : idx_r + 12'd1;
                cur_n_r <= n_s;
                err_r   <= err_s;
            end
            if (rd_s) begin
                rptr_r <= rptr_r + {{(FIFO_AW-1){1'b0}}, 1'b1};
                if (head_s[EOP_B]) begin
                    frame_cnt_r <= frame_cnt_r + 16'd1;
                end
            end
            if (!empty_s) begin
                last_len_r <= head_s[LEN_LO +: 12];
            end
        end
    end

    assign in_ready     = rdy_r;
    assign source_valid = ~empty_s;
    assign source_sop   = ~empty_s & head_s[SOP_B];
    assign source_eop   = ~empty_s & head_s[EOP_B];
    assign source_error = {1'b0, ~empty_s & head_s[ERR_B]};
    assign source_real  = empty_s ? {wData{1'b0}} : head_s[wData +: wData];
    assign source_imag  = empty_s ? {wData{1'b0}} : head_s[0 +: wData];
    assign fftpts_out   = empty_s ? last_len_r : head_s[LEN_LO +: 12];
    assign frame_cnt    = frame_cnt_r;

endmodule

// File: tb/tb_dct_framer.sv
// Directed-plus-random bench for dct_framer, checked against a frame-level
// queue model of the expected output beats.
module tb_dct_framer;

    localparam int DEPTH = 16;
    localparam int DEF   = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_real;
    logic [15:0] in_imag;
    logic [11:0] fftpts_in;
    logic        source_valid;
    logic        source_ready;
    logic [1:0]  source_error;
    logic        source_sop;
    logic        source_eop;
    logic [15:0] source_real;
    logic [15:0] source_imag;
    logic [11:0] fftpts_out;
    logic [15:0] frame_cnt;

    dct_framer #(.wData(16), .FIFO_AW(4), .DEF_PTS(64)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_real(in_real), .in_imag(in_imag), .fftpts_in(fftpts_in),
        .source_valid(source_valid), .source_ready(source_ready),
        .source_error(source_error), .source_sop(source_sop), .source_eop(source_eop),
        .source_real(source_real), .source_imag(source_imag),
        .fftpts_out(fftpts_out), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          sop;
        bit          eop;
        bit          err;
        logic [11:0] len;
        logic [15:0] re;
        logic [15:0] im;
    } beat_t;

    beat_t       q[$];
    int          pos;
    int          cur_n;
    bit          cur_err;
    logic [15:0] fcnt;
    logic [11:0] last_len;
    bit          armed;
    bit          acc;
    bit          pop;
    int          nacc;
    int          checks;
    int          failures;

    function automatic bit len_ok(int x);
        return (x >= 8) && (x <= 2048) && ($countones(x) == 1);
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        pos      = 0;
        cur_n    = DEF;
        cur_err  = 1'b0;
        fcnt     = 16'd0;
        last_len = 12'(DEF);
        armed    = 1'b0;
    endtask

    // One clock: check outputs at the falling edge, then advance the model past the rising edge.
    task automatic cycle();
        bit exp_ready;
        @(negedge clk);
        exp_ready = armed && (q.size() != DEPTH);
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        check("source_valid", 32'(source_valid), 32'(q.size() != 0));
        check("frame_cnt", 32'(frame_cnt), 32'(fcnt));
        if (q.size() != 0) begin
            check("fftpts_out", 32'(fftpts_out), 32'(q[0].len));
            check("sop", 32'(source_sop), 32'(q[0].sop));
            check("eop", 32'(source_eop), 32'(q[0].eop));
            check("error", 32'(source_error), 32'({1'b0, q[0].err}));
            check("real", 32'(source_real), 32'(q[0].re));
            check("imag", 32'(source_imag), 32'(q[0].im));
            last_len = q[0].len;
        end else begin
            check("fftpts_out_hold", 32'(fftpts_out), 32'(last_len));
        end
        acc = in_valid && exp_ready;
        pop = (q.size() != 0) && source_ready;
        @(posedge clk);
        #1;
        armed = 1'b1;
        if (pop) begin
            if (q[0].eop) fcnt = fcnt + 16'd1;
            void'(q.pop_front());
        end
        if (acc) begin
            beat_t b;
            if (pos == 0) begin
                if (len_ok(int'(fftpts_in))) begin
                    cur_n   = int'(fftpts_in);
                    cur_err = 1'b0;
                end else begin
                    cur_err = 1'b1;
                end
            end
            b.sop = (pos == 0);
            b.eop = (pos == cur_n - 1);
            b.err = cur_err;
            b.len = 12'(cur_n);
            b.re  = in_real;
            b.im  = in_imag;
            q.push_back(b);
            pos  = b.eop ? 0 : pos + 1;
            nacc++;
        end
    endtask

    task automatic feed(int n, int pts, int vprob, int rprob);
        int got = 0;
        int guard = 0;
        fftpts_in = 12'(pts);
        while (got < n && guard < 6000) begin
            in_valid     = ($urandom_range(99) < vprob);
            source_ready = ($urandom_range(99) < rprob);
            in_real      = nacc[15:0];
            in_imag      = 16'($urandom);
            cycle();
            if (acc) got++;
            guard++;
        end
        in_valid = 1'b0;
        check("feed_bound", 32'(got), 32'(n));
    endtask

    task automatic drain(int rprob);
        int guard = 0;
        in_valid = 1'b0;
        while (q.size() != 0 && guard < 3000) begin
            source_ready = ($urandom_range(99) < rprob);
            cycle();
            guard++;
        end
        check("drain_bound", 32'(q.size()), 32'd0);
    endtask

    initial begin
        int stall_acc;
        checks       = 0;
        failures     = 0;
        nacc         = 0;
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_real      = 16'd0;
        in_imag      = 16'd0;
        fftpts_in    = 12'd8;
        source_ready = 1'b1;
        model_reset();
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_valid", 32'(source_valid), 32'd0);
        check("rst_error", 32'(source_error), 32'd0);
        check("rst_real", 32'(source_real), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_fftpts_out", 32'(fftpts_out), 32'(DEF));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Two back-to-back frames of 8 with sample values 0..15.
        feed(16, 8, 100, 100);
        drain(100);
        check("two_frames", 32'(frame_cnt), 32'd2);

        // Length change mid-frame takes effect only at the next frame start.
        feed(3, 8, 100, 100);
        feed(21, 16, 100, 100);
        drain(100);

        // Invalid length substitutes the previous valid one and flags error.
        feed(32, 32, 100, 100);
        feed(32, 12, 100, 100);
        feed(32, 32, 100, 100);
        drain(100);

        // Output stalled for 40 cycles with continuous input: exactly DEPTH accepts.
        fftpts_in    = 12'd16;
        source_ready = 1'b0;
        in_valid     = 1'b1;
        stall_acc    = 0;
        for (int i = 0; i < 40; i++) begin
            in_real = nacc[15:0];
            in_imag = 16'($urandom);
            cycle();
            if (acc) stall_acc++;
        end
        check("stall_accepts", 32'(stall_acc), 32'(DEPTH));
        feed(16, 16, 100, 100);
        drain(100);

        // Random backpressure over ten frames of 64.
        feed(640, 64, 80, 50);
        drain(50);

        // Reset mid-frame discards the partial frame.
        feed(5, 16, 100, 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(source_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_sop", 32'(source_sop), 32'd0);
        check("mid_rst_real", 32'(source_real), 32'd0);
        check("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("mid_rst_fftpts_out", 32'(fftpts_out), 32'(DEF));
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        feed(16, 8, 100, 100);
        drain(100);
        check("post_rst_frames", 32'(frame_cnt), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
